// File: rtl/vdp_pkg.sv
// Shared geometry defaults, counter width, mode enum and sync flag bundle
// for the VDP video timing generator.
package vdp_pkg;

    localparam int unsigned CNT_W            = 10;

    localparam int unsigned H_TOTAL_DEF      = 342;
    localparam int unsigned V_TOTAL_PAL_DEF  = 312;
    localparam int unsigned V_TOTAL_NTSC_DEF = 261;
    localparam int unsigned H_START_DEF      = 306;
    localparam int unsigned HS_WIDTH_DEF     = 20;
    localparam int unsigned VS_LINES_DEF     = 4;
    localparam int unsigned HBLANK_END_DEF   = 60;
    localparam int unsigned HBLANK_START_DEF = 341;
    localparam int unsigned VBLANK_LINES_DEF = 8;

    typedef enum logic {
        MODE_NTSC = 1'b0,
        MODE_PAL  = 1'b1
    } vdp_mode_e;

    // Filtered sync/blank flags derived from the counters, before registering
    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic hblank;
        logic vblank;
    } vdp_sync_t;

endpackage

// File: rtl/vdp_sync_gen_if.sv
// Video bundle between the VDP core and the sync generator: raw core sync and
// colour in, filtered sync/colour/blank, frame pulses and counters out.
interface vdp_sync_gen_if #(
    parameter int unsigned COLOR_W = 6
);
    logic                       core_hs_n_i;
    logic                       core_vs_n_i;
    logic [COLOR_W-1:0]         r_i;
    logic [COLOR_W-1:0]         g_i;
    logic [COLOR_W-1:0]         b_i;

    logic                       HS;
    logic                       VS;
    logic [COLOR_W-1:0]         R;
    logic [COLOR_W-1:0]         G;
    logic [COLOR_W-1:0]         B;
    logic                       HBlank;
    logic                       VBlank;
    logic                       line_start_o;
    logic                       frame_start_o;
    logic [vdp_pkg::CNT_W-1:0]  hcnt_o;
    logic [vdp_pkg::CNT_W-1:0]  vcnt_o;

    // Core / display side
    modport master (
        output core_hs_n_i, core_vs_n_i, r_i, g_i, b_i,
        input  HS, VS, R, G, B, HBlank, VBlank,
        input  line_start_o, frame_start_o, hcnt_o, vcnt_o
    );

    // Sync generator side
    modport slave (
        input  core_hs_n_i, core_vs_n_i, r_i, g_i, b_i,
        output HS, VS, R, G, B, HBlank, VBlank,
        output line_start_o, frame_start_o, hcnt_o, vcnt_o
    );

endinterface

// File: rtl/vdp_sync_bit.sv
// Parameterised-depth single-bit synchroniser with a selectable reset value.
module vdp_sync_bit #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_chain[STAGES-1];

endmodule

// File: rtl/vdp_sync_gen.sv
// VDP video timing generator: pixel divider, h/v counters with frame-aligned
// PAL/NTSC switching, registered sync/blank/colour outputs and line/frame pulses.
module vdp_sync_gen
    import vdp_pkg::*;
#(
    parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
    parameter int unsigned V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
    parameter int unsigned H_START      = H_START_DEF,
    parameter int unsigned HS_WIDTH     = HS_WIDTH_DEF,
    parameter int unsigned VS_LINES     = VS_LINES_DEF,
    parameter int unsigned HBLANK_END   = HBLANK_END_DEF,
    parameter int unsigned HBLANK_START = HBLANK_START_DEF,
    parameter int unsigned VBLANK_LINES = VBLANK_LINES_DEF,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned COLOR_W      = 6,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ena,
    input  logic            pal_i,
    input  logic            raw_i,
    vdp_sync_gen_if.slave   vid
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [DIV_W-1:0] r_div;
    vdp_mode_e        r_mode;
    logic             r_hwrap;
    logic             r_fwrap;

    logic             w_pal_sync;
    logic             w_tick;
    logic             w_hend;
    logic             w_vend;
    logic [CNT_W-1:0] w_vlast;
    logic             w_blank;
    vdp_sync_t        w_flt;

    vdp_sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_pal_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (pal_i),
        .q_o     (w_pal_sync)
    );

    assign w_tick  = ena && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_hend  = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_vlast = (r_mode == MODE_PAL) ? CNT_W'(V_TOTAL_PAL - 1) : CNT_W'(V_TOTAL_NTSC - 1);
    assign w_vend  = (r_vcnt == w_vlast);

    // Divider and h/v counters; mode is only re-latched on the frame wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt  <= CNT_W'(H_START);
            r_vcnt  <= '0;
            r_div   <= '0;
            r_mode  <= MODE_PAL;
            r_hwrap <= 1'b0;
            r_fwrap <= 1'b0;
        end else begin
            r_hwrap <= 1'b0;
            r_fwrap <= 1'b0;
            if (ena) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            end
            if (w_tick) begin
                if (w_hend) begin
                    r_hcnt  <= '0;
                    r_hwrap <= 1'b1;
                    if (w_vend) begin
                        r_vcnt  <= '0;
                        r_fwrap <= 1'b1;
                        r_mode  <= w_pal_sync ? MODE_PAL : MODE_NTSC;
                    end else begin
                        r_vcnt <= r_vcnt + CNT_W'(1);
                    end
                end else begin
                    r_hcnt <= r_hcnt + CNT_W'(1);
                end
            end
        end
    end

    // Sync and blank windows decoded from the live counters
    always_comb begin
        w_flt        = '{hs_n: 1'b1, vs_n: 1'b1, hblank: 1'b1, vblank: 1'b1};
        w_flt.hs_n   = !(r_hcnt < CNT_W'(HS_WIDTH));
        w_flt.vs_n   = !(r_vcnt < CNT_W'(VS_LINES));
        w_flt.hblank = (r_hcnt < CNT_W'(HBLANK_END)) || (r_hcnt >= CNT_W'(HBLANK_START));
        w_flt.vblank = (r_vcnt < CNT_W'(VBLANK_LINES));
        w_blank      = w_flt.hblank || w_flt.vblank;
    end

    // Output register stage: one clock behind the counters, updated every clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid.HS            <= 1'b1;
            vid.VS            <= 1'b1;
            vid.R             <= '0;
            vid.G             <= '0;
            vid.B             <= '0;
            vid.HBlank        <= 1'b1;
            vid.VBlank        <= 1'b1;
            vid.line_start_o  <= 1'b0;
            vid.frame_start_o <= 1'b0;
            vid.hcnt_o        <= CNT_W'(H_START);
            vid.vcnt_o        <= '0;
        end else begin
            vid.HS            <= raw_i ? vid.core_hs_n_i : w_flt.hs_n;
            vid.VS            <= raw_i ? vid.core_vs_n_i : w_flt.vs_n;
            vid.R             <= (raw_i || !w_blank) ? vid.r_i : '0;
            vid.G             <= (raw_i || !w_blank) ? vid.g_i : '0;
            vid.B             <= (raw_i || !w_blank) ? vid.b_i : '0;
            vid.HBlank        <= w_flt.hblank;
            vid.VBlank        <= w_flt.vblank;
            vid.line_start_o  <= r_hwrap;
            vid.frame_start_o <= r_fwrap;
            vid.hcnt_o        <= r_hcnt;
            vid.vcnt_o        <= r_vcnt;
        end
    end

endmodule

// File: tb/tb_vdp_sync_gen.sv
// Bench for vdp_sync_gen with reduced geometry: cycle scoreboard from a
// reference model, raw-mode vector table, and frame/line timing sequences.
module tb_vdp_sync_gen;

    localparam int unsigned HT     = 40;
    localparam int unsigned VP     = 12;
    localparam int unsigned VN     = 9;
    localparam int unsigned HSTART = 34;
    localparam int unsigned HSW    = 5;
    localparam int unsigned VSL    = 2;
    localparam int unsigned HBE    = 8;
    localparam int unsigned HBS    = 38;
    localparam int unsigned VBL    = 3;
    localparam int unsigned DIV    = 2;
    localparam int unsigned CW     = 6;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic ena     = 1'b0;
    logic pal_i   = 1'b1;
    logic raw_i   = 1'b0;

    vdp_sync_gen_if #(.COLOR_W(CW)) vid();

    vdp_sync_gen #(
        .H_TOTAL(HT), .V_TOTAL_PAL(VP), .V_TOTAL_NTSC(VN), .H_START(HSTART),
        .HS_WIDTH(HSW), .VS_LINES(VSL), .HBLANK_END(HBE), .HBLANK_START(HBS),
        .VBLANK_LINES(VBL), .CLK_DIV(DIV), .COLOR_W(CW), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .pal_i(pal_i), .raw_i(raw_i), .vid(vid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic hs, vs, hb, vb, ls, fs;
        logic [CW-1:0] r, g, b;
        logic [9:0] h, v;
    } obs_t;

    typedef struct {
        logic hs, vs;
        logic [CW-1:0] r, g, b;
        logic ehs, evs;
        logic [CW-1:0] er, eg, eb;
    } raw_vec_t;

    typedef struct {
        logic ena;
        int   cycles;
    } ena_row_t;

    obs_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    function automatic obs_t reset_obs();
        obs_t e;
        e = '0;
        e.hs = 1'b1; e.vs = 1'b1; e.hb = 1'b1; e.vb = 1'b1;
        e.h = 10'(HSTART);
        return e;
    endfunction

    function automatic obs_t dut_obs();
        obs_t e;
        e.hs = vid.HS; e.vs = vid.VS; e.hb = vid.HBlank; e.vb = vid.VBlank;
        e.ls = vid.line_start_o; e.fs = vid.frame_start_o;
        e.r = vid.R; e.g = vid.G; e.b = vid.B;
        e.h = vid.hcnt_o; e.v = vid.vcnt_o;
        return e;
    endfunction

    // Reference model: expected outputs pushed on each edge
    int unsigned m_h = HSTART, m_v = 0, m_div = 0;
    logic m_pal = 1'b1, m_hw = 1'b0, m_fw = 1'b0;
    logic [1:0] m_sync = 2'b11;

    always @(posedge clk or negedge reset_n) begin : model
        obs_t e;
        int unsigned nh, nv, nd;
        logic nhw, nfw, npal, hb, vb;
        if (!reset_n) begin
            m_h <= HSTART; m_v <= 0; m_div <= 0; m_pal <= 1'b1;
            m_hw <= 1'b0; m_fw <= 1'b0; m_sync <= 2'b11;
            sb.delete();
            sb.push_back(reset_obs());
        end else begin
            hb = (m_h < HBE) || (m_h >= HBS);
            vb = (m_v < VBL);
            e.hs = raw_i ? vid.core_hs_n_i : (m_h >= HSW);
            e.vs = raw_i ? vid.core_vs_n_i : (m_v >= VSL);
            e.hb = hb; e.vb = vb; e.ls = m_hw; e.fs = m_fw;
            e.r = (raw_i || !(hb || vb)) ? vid.r_i : '0;
            e.g = (raw_i || !(hb || vb)) ? vid.g_i : '0;
            e.b = (raw_i || !(hb || vb)) ? vid.b_i : '0;
            e.h = 10'(m_h); e.v = 10'(m_v);
            sb.push_back(e);
            nh = m_h; nv = m_v; nd = m_div; npal = m_pal; nhw = 1'b0; nfw = 1'b0;
            if (ena) begin
                if (m_div == DIV - 1) begin
                    nd = 0;
                    if (m_h == HT - 1) begin
                        nh = 0; nhw = 1'b1;
                        if (m_v == (m_pal ? VP : VN) - 1) begin
                            nv = 0; nfw = 1'b1; npal = m_sync[1];
                        end else nv = m_v + 1;
                    end else nh = m_h + 1;
                end else nd = m_div + 1;
            end
            m_h <= nh; m_v <= nv; m_div <= nd; m_pal <= npal;
            m_hw <= nhw; m_fw <= nfw; m_sync <= {m_sync[0], pal_i};
        end
    end

    always @(negedge clk) begin : scoreboard
        obs_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb", 64'(dut_obs()), 64'(e));
        end
    end

    task automatic wait_line(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!vid.line_start_o && n < 2000);
        if (!vid.line_start_o) check("line_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!vid.frame_start_o && n < 2000);
        if (!vid.frame_start_o) check("frame_timeout", 64'(0), 64'(1));
    endtask

    // Called at a negedge where frame_start_o is high; stops at the next one
    task automatic measure_frame(input int sw_v, output int len, output int hs_lo,
                                 output int vs_lo, output int vis);
        len = 0; hs_lo = 0; vs_lo = 0; vis = 0;
        do begin
            if (!vid.HS) hs_lo++;
            if (!vid.VS) vs_lo++;
            if (vid.R == 6'h3F) vis++;
            if (sw_v >= 0 && vid.vcnt_o == 10'(sw_v)) pal_i = 1'b0;
            len++;
            @(negedge clk);
        end while (!vid.frame_start_o && len < 2000);
        if (!vid.frame_start_o) check("frame_timeout", 64'(0), 64'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        raw_vec_t rtab[8];
        ena_row_t etab[5];
        int n, len, hs_lo, vs_lo, vis, pulses;

        rtab[0] = '{1'b0, 1'b0, 6'h00, 6'h3F, 6'h15, 1'b0, 1'b0, 6'h00, 6'h3F, 6'h15};
        rtab[1] = '{1'b1, 1'b0, 6'h2A, 6'h01, 6'h3E, 1'b1, 1'b0, 6'h2A, 6'h01, 6'h3E};
        rtab[2] = '{1'b0, 1'b1, 6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b1, 6'h3F, 6'h3F, 6'h3F};
        rtab[3] = '{1'b1, 1'b1, 6'h11, 6'h22, 6'h33, 1'b1, 1'b1, 6'h11, 6'h22, 6'h33};
        rtab[4] = '{1'b0, 1'b0, 6'h05, 6'h00, 6'h30, 1'b0, 1'b0, 6'h05, 6'h00, 6'h30};
        rtab[5] = '{1'b1, 1'b0, 6'h00, 6'h00, 6'h00, 1'b1, 1'b0, 6'h00, 6'h00, 6'h00};
        rtab[6] = '{1'b0, 1'b1, 6'h1C, 6'h07, 6'h38, 1'b0, 1'b1, 6'h1C, 6'h07, 6'h38};
        rtab[7] = '{1'b1, 1'b1, 6'h3F, 6'h2A, 6'h15, 1'b1, 1'b1, 6'h3F, 6'h2A, 6'h15};
        etab[0] = '{1'b0, 7};
        etab[1] = '{1'b1, 3};
        etab[2] = '{1'b0, 5};
        etab[3] = '{1'b1, 1};
        etab[4] = '{1'b0, 12};

        vid.core_hs_n_i = 1'b1; vid.core_vs_n_i = 1'b1;
        vid.r_i = 6'h3F; vid.g_i = 6'h2A; vid.b_i = 6'h15;

        repeat (3) @(negedge clk);
        check("reset_vals", 64'(dut_obs()), 64'(reset_obs()));

        // Release: line_start after 2*(HT-HSTART) clocks plus the output stage
        ena = 1'b1; reset_n = 1'b1;
        wait_line(n);
        check("first_line_start", 64'(n), 64'(2 * (HT - HSTART) + 1));
        @(negedge clk);
        check("line_start_single", 64'(vid.line_start_o), 64'(0));

        wait_frame();
        measure_frame(-1, len, hs_lo, vs_lo, vis);
        check("pal_frame_len", 64'(len), 64'(HT * VP * DIV));
        check("pal_hs_low", 64'(hs_lo), 64'(HSW * DIV * VP));
        check("pal_vs_low", 64'(vs_lo), 64'(VSL * HT * DIV));
        check("pal_visible", 64'(vis), 64'((HBS - HBE) * DIV * (VP - VBL)));

        // Mid-frame switch to NTSC only takes effect from the next frame
        measure_frame(5, len, hs_lo, vs_lo, vis);
        check("switch_frame_len", 64'(len), 64'(HT * VP * DIV));
        measure_frame(-1, len, hs_lo, vs_lo, vis);
        check("ntsc_frame_len", 64'(len), 64'(HT * VN * DIV));
        check("ntsc_hs_low", 64'(hs_lo), 64'(HSW * DIV * VN));
        check("ntsc_visible", 64'(vis), 64'((HBS - HBE) * DIV * (VN - VBL)));

        // Enable gaps: no new line pulses while ena is low
        for (int i = 0; i < 5; i++) begin
            ena = etab[i].ena;
            pulses = 0;
            for (int c = 0; c < etab[i].cycles; c++) begin
                @(negedge clk);
                if (c > 0 && vid.line_start_o) pulses++;
            end
            if (!etab[i].ena) check("ena_low_no_pulse", 64'(pulses), 64'(0));
        end
        ena = 1'b1;

        // Raw pass-through vectors, one clock latency
        raw_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            vid.core_hs_n_i = rtab[i].hs; vid.core_vs_n_i = rtab[i].vs;
            vid.r_i = rtab[i].r; vid.g_i = rtab[i].g; vid.b_i = rtab[i].b;
            @(negedge clk);
            check("raw_vec", 64'({vid.HS, vid.VS, vid.R, vid.G, vid.B}),
                  64'({rtab[i].ehs, rtab[i].evs, rtab[i].er, rtab[i].eg, rtab[i].eb}));
        end
        for (int i = 0; i < 60; i++) begin
            vid.core_hs_n_i = 1'($urandom_range(0, 1));
            vid.core_vs_n_i = 1'($urandom_range(0, 1));
            vid.r_i = CW'($urandom_range(0, 63));
            @(negedge clk);
        end
        raw_i = 1'b0;
        vid.core_hs_n_i = 1'b1; vid.core_vs_n_i = 1'b1; vid.r_i = 6'h3F;
        repeat (300) @(negedge clk);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 64'(dut_obs()), 64'(reset_obs()));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_line(n);
        check("restart_line_start", 64'(n), 64'(2 * (HT - HSTART) + 1));
        repeat (100) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vdp_sync_gen.md
VDP_SYNC_GEN -- requirements
Module: vdp_sync_gen

Interface
REQ-001 Parameter H_TOTAL, default 342: pixel ticks per line.
REQ-002 Parameter V_TOTAL_PAL, default 312; V_TOTAL_NTSC, default 261: lines per frame in each mode.
REQ-003 Parameter H_START, default 306: horizontal counter value after reset (phase shift, 0..H_TOTAL-1).
REQ-004 Parameters HS_WIDTH 20, VS_LINES 4, HBLANK_END 60, HBLANK_START 341, VBLANK_LINES 8: sync and blank geometry, all in counter units.
REQ-005 Parameters CLK_DIV 2 (ena pulses per pixel tick, >=1), COLOR_W 6 (colour width), SYNC_STAGES 2 (>=2).
REQ-006 clk  in  1  system clock; all state on rising edge.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 ena  in  1  clock enable, nominal 10.7 MHz rate.
REQ-009 pal_i  in  1  asynchronous mode select, 1=PAL, 0=NTSC.
REQ-010 raw_i  in  1  1 = pass core sync/colour through unfiltered.
REQ-011 core_hs_n_i, core_vs_n_i  in  1 each  raw sync from VDP core.
REQ-012 r_i, g_i, b_i  in  COLOR_W each  raw colour from VDP core.
REQ-013 HS, VS  out  1 each  active-low sync.
REQ-014 R, G, B  out  COLOR_W each  output colour.
REQ-015 HBlank, VBlank  out  1 each  active-high blank.
REQ-016 line_start_o, frame_start_o  out  1 each  one-clk pulses.
REQ-017 hcnt_o, vcnt_o  out  10 each  current counters.

Function
REQ-018 pal_i SHALL pass through a SYNC_STAGES-deep flop chain before use.
REQ-019 Divider counts ena-qualified cycles 0..CLK_DIV-1; pixel tick = ena AND div==CLK_DIV-1; div wraps to 0 on tick.
REQ-020 On tick hcnt increments; at hcnt==H_TOTAL-1 it wraps to 0 and vcnt increments.
REQ-021 vcnt wraps to 0 at vcnt==V_TOTAL-1 coincident with hcnt wrap; V_TOTAL is latched mode's total.
REQ-022 Latched mode updates from synchronised pal_i only at the frame wrap (hcnt and vcnt both wrapping); mid-frame toggles have no effect until then.
REQ-023 If latched V_TOTAL shrinks and vcnt already exceeds new V_TOTAL-1 (impossible by REQ-022) — no clamp logic required; counter compare uses equality only.
REQ-024 Filtered: HS=0 iff hcnt<HS_WIDTH; VS=0 iff vcnt<VS_LINES; HBlank=1 iff hcnt<HBLANK_END or hcnt>=HBLANK_START; VBlank=1 iff vcnt<VBLANK_LINES.
REQ-025 Filtered colour = 0 when HBlank or VBlank, else r_i/g_i/b_i.
REQ-026 raw_i=1: HS/VS/R/G/B = core inputs; HBlank/VBlank still filtered.
REQ-027 All outputs registered every clk from current counters/inputs: latency exactly 1 clk.
REQ-028 line_start_o pulses 1 clk after hcnt becomes 0; frame_start_o additionally requires vcnt==0.
REQ-029 ena low: counters, divider and pulses hold; registered outputs still track inputs.

Reset
REQ-030 reset_n low: hcnt=H_START, vcnt=0, div=0, latched mode=PAL, sync chain=1.
REQ-031 Outputs on reset: HS=1, VS=1, R/G/B=0, HBlank=1, VBlank=1, pulses=0.
REQ-032 Reset assertion mid-line SHALL take effect immediately without waiting for clk; release synchronous use from next edge.

Structure
REQ-033 Shared package vdp_pkg holds default geometry constants (342/312/261/20/4/60/341/8) and a mode enum (MODE_NTSC, MODE_PAL).
REQ-034 One sub-module vdp_sync_bit (parameterised-depth synchroniser) for pal_i; counters and output logic inline.

Verification
REQ-035 Reset release, ena=1 constant, CLK_DIV=2 -> hcnt reaches 0 after 72 clk (36 ticks), line_start_o pulses once next clk.
REQ-036 PAL, run full frame -> frame_start_o period exactly 342*312*2 = 213408 clk; HS low 20 ticks/line, VS low 4 lines.
REQ-037 Toggle pal_i to 0 at vcnt=100 -> current frame still 312 lines, next frame 261 lines (178524 clk).
REQ-038 r_i=6'h3F constant -> R=0 for hcnt 0..59 and 341, and for vcnt 0..7; R=3F elsewhere, 1 clk after counter.
REQ-039 raw_i=1, core_hs_n_i toggled arbitrarily -> HS follows with 1 clk delay; HBlank unchanged pattern.
REQ-040 Assert reset_n low mid-frame for 3 clk -> outputs reach reset values without clk edge; counting restarts from hcnt=306, vcnt=0.
